// File: rtl/dispatcher_pkg.sv
// Shared state encoding and sizing helpers for the block job dispatcher.
package dispatcher_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      OFFER,
      DRAIN,
      DONE
   } disp_state_t;

   localparam int INDEX_W = 8;

   function automatic int job_cnt_w(input int iw);
      return 2 * iw;
   endfunction

   localparam int JOB_CNT_W = job_cnt_w(INDEX_W);

endpackage

// File: rtl/proc_free_picker.sv
// Lowest-index free processor: one-hot pick plus any-free flag.
module proc_free_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_free,
   output logic [N-1:0] o_onehot,
   output logic         o_valid
);

   // Two's-complement trick isolates the lowest set bit.
   assign o_onehot = i_free & (~i_free + N'(1));
   assign o_valid  = |i_free;

endmodule

// File: rtl/block_job_dispatcher.sv
// Walks C-blocks row-major and hands each to a free processor
// over a 4-phase index handshake; tracks results and completion.
module block_job_dispatcher
   import dispatcher_pkg::*;
#(
   parameter int NUM_PROC    = 4,
   parameter int index_width = INDEX_W,
   parameter int cell_width  = 32
) (
   input  logic                   in_clk,
   input  logic                   in_reset,
   input  logic                   in_start,
   input  logic [index_width-1:0] in_rows_blk,
   input  logic [index_width-1:0] in_cols_blk,
   input  logic [index_width-1:0] in_mu,
   input  logic [cell_width-1:0]  in_config,
   output logic [index_width-1:0] out_row_index,
   output logic [index_width-1:0] out_col_index,
   output logic [index_width-1:0] out_mu,
   output logic [cell_width-1:0]  out_config,
   output logic [NUM_PROC-1:0]    out_index_ready,
   input  logic [NUM_PROC-1:0]    in_index_ack,
   input  logic [NUM_PROC-1:0]    in_result_ready,
   output logic [NUM_PROC-1:0]    out_proc_busy,
   output logic                   out_busy,
   output logic                   out_done,
   output logic                   out_protocol_err
);

   localparam int JW = job_cnt_w(index_width);

   disp_state_t r_state;
   disp_state_t w_state_nxt;

   logic [index_width-1:0] r_row;
   logic [index_width-1:0] r_col;
   logic [index_width-1:0] r_cols;
   logic [index_width-1:0] r_row_o;
   logic [index_width-1:0] r_col_o;
   logic [index_width-1:0] r_mu;
   logic [cell_width-1:0]  r_cfg;
   logic [JW-1:0]          r_total;
   logic [JW-1:0]          r_issued;
   logic [JW-1:0]          r_done_cnt;
   logic [NUM_PROC-1:0]    r_ready;
   logic [NUM_PROC-1:0]    r_busy;
   logic [NUM_PROC-1:0]    r_pend;
   logic [NUM_PROC-1:0]    r_res_q;
   logic                   r_busy_o;
   logic                   r_done;
   logic                   r_err;

   logic [NUM_PROC-1:0]    w_free;
   logic [NUM_PROC-1:0]    w_pick;
   logic                   w_pick_vld;
   logic [NUM_PROC-1:0]    w_acc;
   logic                   w_acc_any;
   logic [NUM_PROC-1:0]    w_rise;
   logic [NUM_PROC-1:0]    w_good;
   logic [NUM_PROC-1:0]    w_bad;
   logic                   w_last;
   logic                   w_col_wrap;
   logic [JW-1:0]          w_total_in;
   logic [JW-1:0]          w_pop;

   // A processor is offered work only once idle and its ack has fallen.
   assign w_free = ~r_busy & ~r_pend;

   proc_free_picker #(
      .N (NUM_PROC)
   ) u_picker (
      .i_free   (w_free),
      .o_onehot (w_pick),
      .o_valid  (w_pick_vld)
   );

   assign w_acc      = (r_state == OFFER) ? (r_ready & in_index_ack) : '0;
   assign w_acc_any  = |w_acc;
   assign w_rise     = in_result_ready & ~r_res_q;
   assign w_good     = w_rise & r_busy;
   assign w_bad      = w_rise & ~r_busy;
   assign w_last     = (r_issued + JW'(1)) == r_total;
   assign w_col_wrap = r_col == (r_cols - index_width'(1));
   assign w_total_in = JW'(in_rows_blk) * JW'(in_cols_blk);

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_PROC; i++) begin
         w_pop = w_pop + JW'(w_good[i]);
      end
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (in_start) begin
               w_state_nxt = (w_total_in == '0) ? DONE : SELECT;
            end
         end
         SELECT: begin
            if (w_pick_vld) begin
               w_state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (w_acc_any) begin
               w_state_nxt = w_last ? DRAIN : SELECT;
            end
         end
         DRAIN: begin
            if (r_done_cnt == r_total) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_row      <= '0;
         r_col      <= '0;
         r_cols     <= '0;
         r_row_o    <= '0;
         r_col_o    <= '0;
         r_mu       <= '0;
         r_cfg      <= '0;
         r_total    <= '0;
         r_issued   <= '0;
         r_done_cnt <= '0;
         r_ready    <= '0;
         r_busy     <= '0;
         r_pend     <= '0;
         r_res_q    <= '0;
         r_busy_o   <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_res_q <= in_result_ready;
         r_pend  <= (r_pend | w_acc) & in_index_ack;
         unique case (r_state)
            IDLE: begin
               if (in_start) begin
                  r_cols     <= in_cols_blk;
                  r_mu       <= in_mu;
                  r_cfg      <= in_config;
                  r_total    <= w_total_in;
                  r_issued   <= '0;
                  r_done_cnt <= '0;
                  r_row      <= '0;
                  r_col      <= '0;
                  r_err      <= 1'b0;
                  r_busy_o   <= 1'b1;
               end
            end
            SELECT: begin
               if (w_pick_vld) begin
                  r_row_o <= r_row;
                  r_col_o <= r_col;
                  r_ready <= w_pick;
               end
            end
            OFFER: begin
               if (w_acc_any) begin
                  r_ready  <= '0;
                  r_issued <= r_issued + JW'(1);
                  if (w_col_wrap) begin
                     r_col <= '0;
                     r_row <= r_row + index_width'(1);
                  end else begin
                     r_col <= r_col + index_width'(1);
                  end
               end
            end
            DONE: begin
               r_done   <= 1'b1;
               r_busy_o <= 1'b0;
            end
            default: begin
            end
         endcase
         if (r_state != IDLE) begin
            r_busy     <= (r_busy & ~w_good) | w_acc;
            r_done_cnt <= r_done_cnt + w_pop;
            if (|w_bad) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign out_row_index    = r_row_o;
   assign out_col_index    = r_col_o;
   assign out_mu           = r_mu;
   assign out_config       = r_cfg;
   assign out_index_ready  = r_ready;
   assign out_proc_busy    = r_busy;
   assign out_busy         = r_busy_o;
   assign out_done         = r_done;
   assign out_protocol_err = r_err;

endmodule

// File: tb/tb_block_job_dispatcher.sv
// Bench for block_job_dispatcher: table jobs, corner sequences and
// randomized jobs checked against a processor-level reference model.
`timescale 1ns/1ps
module tb_block_job_dispatcher;

   localparam int NP = 4;
   localparam int IW = 8;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [IW-1:0] rows_blk;
   logic [IW-1:0] cols_blk;
   logic [IW-1:0] mu;
   logic [CW-1:0] cfg;
   logic [IW-1:0] row_idx;
   logic [IW-1:0] col_idx;
   logic [IW-1:0] mu_o;
   logic [CW-1:0] cfg_o;
   logic [NP-1:0] rdy;
   logic [NP-1:0] ack;
   logic [NP-1:0] res;
   logic [NP-1:0] pbusy;
   logic          busy;
   logic          done;
   logic          perr;

   always #5 clk = ~clk;

   block_job_dispatcher #(
      .NUM_PROC    (NP),
      .index_width (IW),
      .cell_width  (CW)
   ) dut (
      .in_clk           (clk),
      .in_reset         (rst_n),
      .in_start         (start),
      .in_rows_blk      (rows_blk),
      .in_cols_blk      (cols_blk),
      .in_mu            (mu),
      .in_config        (cfg),
      .out_row_index    (row_idx),
      .out_col_index    (col_idx),
      .out_mu           (mu_o),
      .out_config       (cfg_o),
      .out_index_ready  (rdy),
      .in_index_ack     (ack),
      .in_result_ready  (res),
      .out_proc_busy    (pbusy),
      .out_busy         (busy),
      .out_done         (done),
      .out_protocol_err (perr)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int st_cyc = 0;
   bit mdl_en = 1'b0;
   bit res_auto = 1'b1;
   int ack_dly [NP];
   int res_dly [NP];
   int ack_cnt [NP];
   int res_cnt [NP];
   int res_hi [NP];
   bit holding [NP];
   int cap_r [NP];
   int cap_c [NP];
   int lg_n;
   int lg_r [512];
   int lg_c [512];
   int lg_p [512];
   int job_cols;
   int first_rdy;
   int done_rel;
   int done_n;
   int res_fired;
   int res_at_done;
   int hold_viol;
   int ord_bad;

   always @(posedge clk) cyc <= cyc + 1;

   // Processor model: acks offers after a delay, reports results later,
   // and logs each accepted block against the row-major walk order.
   always @(negedge clk) begin
      if (mdl_en) begin
         if (|rdy && first_rdy < 0) first_rdy = cyc - st_cyc;
         if (done) begin
            done_n++;
            if (done_n == 1) begin
               done_rel = cyc - st_cyc;
               res_at_done = res_fired;
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (ack[p]) begin
               if (!rdy[p]) begin
                  ack[p] = 1'b0;
                  if (holding[p]) hold_viol++;
                  holding[p] = 1'b1;
                  res_cnt[p] = res_dly[p];
                  if (lg_n < 512) begin
                     lg_r[lg_n] = cap_r[p];
                     lg_c[lg_n] = cap_c[p];
                     lg_p[lg_n] = p;
                  end
                  if (job_cols == 0 || cap_r[p] != lg_n / job_cols ||
                      cap_c[p] != lg_n % job_cols) ord_bad++;
                  lg_n++;
               end
            end else if (rdy[p]) begin
               if (ack_cnt[p] >= ack_dly[p]) begin
                  ack[p] = 1'b1;
                  ack_cnt[p] = 0;
                  cap_r[p] = int'(row_idx);
                  cap_c[p] = int'(col_idx);
               end else begin
                  ack_cnt[p]++;
               end
            end
            if (res_auto) begin
               if (res_hi[p] > 0) begin
                  res_hi[p]--;
                  if (res_hi[p] == 0) res[p] = 1'b0;
               end else if (holding[p] && !ack[p]) begin
                  if (res_cnt[p] > 0) begin
                     res_cnt[p]--;
                  end else begin
                     res[p] = 1'b1;
                     res_hi[p] = 2;
                     holding[p] = 1'b0;
                     res_fired++;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string nm, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   task automatic model_clear();
      ack = '0;
      res = '0;
      for (int p = 0; p < NP; p++) begin
         ack_cnt[p] = 0;
         res_cnt[p] = 0;
         res_hi[p] = 0;
         holding[p] = 1'b0;
      end
   endtask

   task automatic set_delays(input int a, input int r);
      for (int p = 0; p < NP; p++) begin
         ack_dly[p] = a;
         res_dly[p] = r;
      end
   endtask

   task automatic start_job(input int r, input int c, input int m,
                            input logic [31:0] cf);
      lg_n = 0;
      first_rdy = -1;
      done_rel = -1;
      done_n = 0;
      res_fired = 0;
      res_at_done = -1;
      hold_viol = 0;
      ord_bad = 0;
      job_cols = c;
      rows_blk = IW'(r);
      cols_blk = IW'(c);
      mu = IW'(m);
      cfg = cf;
      start = 1'b1;
      st_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int tmo);
      int k;
      k = 0;
      while (done_n == 0 && k < tmo) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_done_seen"}, longint'(done_n > 0), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_lg(input int n, input int tmo);
      int k;
      k = 0;
      while (lg_n < n && k < tmo) begin
         @(negedge clk);
         k++;
      end
   endtask

   typedef struct {
      int          r;
      int          c;
      int          m;
      logic [31:0] cf;
      int          exp_n;
      int          exp_lr;
      int          exp_lc;
   } vec_t;

   vec_t vt [7];

   initial begin
      vt[0] = '{1, 1, 3, 32'h0000_00A5, 1, 0, 0};
      vt[1] = '{2, 3, 5, 32'h1234_5678, 6, 1, 2};
      vt[2] = '{4, 1, 2, 32'hDEAD_BEEF, 4, 3, 0};
      vt[3] = '{1, 5, 9, 32'h0000_0001, 5, 0, 4};
      vt[4] = '{3, 2, 1, 32'h8000_0000, 6, 2, 1};
      vt[5] = '{255, 1, 255, 32'hFFFF_FFFF, 255, 254, 0};
      vt[6] = '{1, 255, 4, 32'h0F0F_0F0F, 255, 0, 254};

      rst_n = 1'b0;
      start = 1'b0;
      rows_blk = '0;
      cols_blk = '0;
      mu = '0;
      cfg = '0;
      model_clear();
      set_delays(0, 10);
      repeat (3) @(negedge clk);
      check("rst_ready", rdy, 0);
      check("rst_pbusy", pbusy, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", perr, 0);
      check("rst_row", row_idx, 0);
      check("rst_cfg", cfg_o, 0);
      rst_n = 1'b1;
      mdl_en = 1'b1;
      @(negedge clk);

      // T1: 2x2 across four processors
      set_delays(0, 10);
      start_job(2, 2, 7, 32'h00C0_FFEE);
      wait_done("t1", 200);
      check("t1_first_ready", first_rdy, 2);
      for (int i = 0; i < 4; i++) begin
         check("t1_proc", lg_p[i], i);
         check("t1_row", lg_r[i], i / 2);
         check("t1_col", lg_c[i], i % 2);
      end
      check("t1_results_at_done", res_at_done, 4);
      check("t1_done_once", done_n, 1);
      check("t1_busy_low", busy, 0);
      check("t1_mu", mu_o, 7);
      check("t1_cfg", cfg_o, 32'h00C0_FFEE);

      // T2: p1 reports first and receives the fifth block
      model_clear();
      set_delays(0, 40);
      res_dly[1] = 10;
      start_job(3, 3, 1, 32'h2);
      wait_done("t2", 600);
      check("t2_p5_proc", lg_p[4], 1);
      check("t2_p5_row", lg_r[4], 1);
      check("t2_p5_col", lg_c[4], 1);
      check("t2_count", lg_n, 9);
      check("t2_order", ord_bad, 0);
      check("t2_results_at_done", res_at_done, 9);
      check("t2_done_once", done_n, 1);
      check("t2_reuse", hold_viol, 0);

      // T3: empty job
      model_clear();
      start_job(0, 5, 0, 32'h3);
      wait_done("t3", 20);
      check("t3_done_latency", done_rel, 2);
      check("t3_no_ready", first_rdy, -1);
      check("t3_count", lg_n, 0);
      check("t3_busy_low", busy, 0);

      // Table of jobs, including the widest legal rows/cols
      for (int v = 0; v < 7; v++) begin
         model_clear();
         set_delays(1, 5);
         start_job(vt[v].r, vt[v].c, vt[v].m, vt[v].cf);
         wait_done("tab", 4000);
         check("tab_count", lg_n, vt[v].exp_n);
         check("tab_last_row", lg_r[(lg_n > 0) ? lg_n - 1 : 0], vt[v].exp_lr);
         check("tab_last_col", lg_c[(lg_n > 0) ? lg_n - 1 : 0], vt[v].exp_lc);
         check("tab_order", ord_bad, 0);
         check("tab_mu", mu_o, vt[v].m);
         check("tab_cfg", cfg_o, vt[v].cf);
         check("tab_done_once", done_n, 1);
         check("tab_err", perr, 0);
      end

      // T4: simultaneous results from p0 and p2
      model_clear();
      res_auto = 1'b0;
      set_delays(0, 0);
      start_job(1, 3, 1, 32'h4);
      wait_lg(3, 50);
      check("t4_issued", lg_n, 3);
      repeat (2) @(negedge clk);
      check("t4_busy_before", pbusy, 4'b0111);
      res[0] = 1'b1;
      res[2] = 1'b1;
      @(negedge clk);
      check("t4_busy_after", pbusy, 4'b0010);
      check("t4_no_done", done_n, 0);
      res = '0;
      @(negedge clk);
      res[1] = 1'b1;
      wait_done("t4", 10);
      check("t4_done_once", done_n, 1);
      check("t4_err", perr, 0);
      res = '0;

      // T6: result edge from an idle processor
      model_clear();
      start_job(1, 1, 2, 32'h6);
      wait_lg(1, 50);
      check("t6_issued", lg_n, 1);
      @(negedge clk);
      res[3] = 1'b1;
      @(negedge clk);
      res[3] = 1'b0;
      check("t6_err_set", perr, 1);
      check("t6_busy", pbusy, 4'b0001);
      repeat (3) @(negedge clk);
      check("t6_no_early_done", done_n, 0);
      check("t6_err_sticky", perr, 1);
      res[0] = 1'b1;
      wait_done("t6", 10);
      check("t6_err_after_done", perr, 1);
      res = '0;
      @(negedge clk);
      model_clear();
      res_auto = 1'b1;
      set_delays(0, 4);
      start_job(1, 1, 0, 32'h0);
      check("t6_err_cleared", perr, 0);
      wait_done("t6b", 50);

      // T5: asynchronous reset while offering to p2
      model_clear();
      res_auto = 1'b0;
      set_delays(0, 4);
      ack_dly[2] = 1000;
      start_job(1, 4, 0, 32'h5);
      for (int k = 0; k < 50 && rdy != 4'b0100; k++) @(negedge clk);
      check("t5_offer_p2", rdy, 4'b0100);
      check("t5_busy_pre", pbusy, 4'b0011);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_ready", rdy, 0);
      check("t5_rst_pbusy", pbusy, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      @(negedge clk);
      model_clear();
      set_delays(0, 4);
      res_auto = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      start_job(1, 2, 0, 32'h0);
      wait_done("t5", 100);
      check("t5_restart_row", lg_r[0], 0);
      check("t5_restart_col", lg_c[0], 0);
      check("t5_restart_proc", lg_p[0], 0);
      check("t5_restart_count", lg_n, 2);

      // Randomized jobs
      for (int j = 0; j < 8; j++) begin
         int r;
         int c;
         r = int'($urandom_range(1, 5));
         c = int'($urandom_range(1, 5));
         model_clear();
         for (int p = 0; p < NP; p++) begin
            ack_dly[p] = int'($urandom_range(0, 3));
            res_dly[p] = int'($urandom_range(3, 20));
         end
         start_job(r, c, j, $urandom);
         wait_done("rnd", 3000);
         check("rnd_count", lg_n, r * c);
         check("rnd_order", ord_bad, 0);
         check("rnd_results_at_done", res_at_done, r * c);
         check("rnd_reuse", hold_viol, 0);
         check("rnd_done_once", done_n, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
